// File: rtl/hand_pkg.sv
// hand_pkg: shared hand gesture codes, also used by the LED gesture FSM
// Codes are {upper sensor, lower sensor}.
package hand_pkg;
   localparam logic [1:0] HAND_NONE = 2'b00;
   localparam logic [1:0] HAND_LOW  = 2'b01;
   localparam logic [1:0] HAND_HIGH = 2'b10;
   localparam logic [1:0] HAND_BOTH = 2'b11;
endpackage

// File: rtl/hand_debounce.sv
// hand_debounce: per-channel tick-sampled debouncer
// Ports: clk, reset (async, active-high), tick (sample strobe),
//        din_sync (synchronized raw bit), dout (stable bit).
// A change commits only after DEB_TICKS consecutive disagreeing ticks.
// The counter returns to 0 on every commit or agreement, so it never wraps.
module hand_debounce #(
   parameter int DEB_TICKS = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic din_sync,
   output logic dout
);
   localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
   logic          st;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st  <= 1'b0;
         cnt <= '0;
      end else if (tick) begin
         if (din_sync == st)
            cnt <= '0;
         else if (cnt == CW'(DEB_TICKS - 1)) begin
            st  <= din_sync;
            cnt <= '0;
         end else
            cnt <= cnt + CW'(1);
      end
   assign dout = st;
endmodule

// File: rtl/hand_sensor_encoder.sv
// hand_sensor_encoder: synchronizes, debounces and encodes two proximity sensors
// Ports: clk, reset (async, active-high), sens_a/sens_b (raw, async),
//        hand {b,a} registered code, hand_valid (one-clk change pulse),
//        stuck (stuck-hand flag).
// Optional: define HAND_STUCK_EN to force hand to 00 after STUCK_TICKS ticks
// of continuous non-zero hand; otherwise stuck is tied 0.
module hand_sensor_encoder
   import hand_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TICK_HZ     = 1_000,
   parameter int DEB_TICKS   = 20,
   parameter int STUCK_TICKS = 10_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sens_a,
   input  logic       sens_b,
   output logic [1:0] hand,
   output logic       hand_valid,
   output logic       stuck
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   logic [1:0]    sync_a, sync_b;
   logic [PW-1:0] pcnt;
   logic          tick;
   logic          st_a, st_b;
   logic [1:0]    raw, hand_n;
   logic          stuck_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[0], sens_a};
         sync_b <= {sync_b[0], sens_b};
      end
   assign tick = (pcnt == PW'(DIV - 1));
   always_ff @(posedge clk or posedge reset)
      if (reset)
         pcnt <= '0;
      else
         pcnt <= tick ? '0 : pcnt + PW'(1);
   hand_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_a (
      .clk(clk), .reset(reset), .tick(tick), .din_sync(sync_a[1]), .dout(st_a)
   );
   hand_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_b (
      .clk(clk), .reset(reset), .tick(tick), .din_sync(sync_b[1]), .dout(st_b)
   );
   assign raw = {st_b, st_a};
`ifdef HAND_STUCK_EN
   localparam int SW = $clog2(STUCK_TICKS + 1);
   logic [SW-1:0] scnt;
   logic          trip;
   assign trip = tick && (hand != HAND_NONE) && (scnt == SW'(STUCK_TICKS - 1));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         scnt    <= '0;
         stuck_q <= 1'b0;
      end else begin
         scnt    <= (hand == HAND_NONE) ? '0 : tick ? scnt + SW'(1) : scnt;
         stuck_q <= trip ? 1'b1 : (raw == HAND_NONE) ? 1'b0 : stuck_q;
      end
   // Stuck holds hand at 00 until both debounced channels have gone low.
   assign hand_n = (trip || stuck_q) ? HAND_NONE : raw;
`else
   assign stuck_q = 1'b0;
   assign hand_n  = raw;
`endif
   // Both channels are sampled together, so a simultaneous commit is one step.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hand       <= HAND_NONE;
         hand_valid <= 1'b0;
      end else begin
         hand       <= hand_n;
         hand_valid <= (hand_n != hand);
      end
   assign stuck = stuck_q;
endmodule

// File: tb/tb_hand_sensor_encoder.sv
// tb_hand_sensor_encoder: directed self-checking bench, 10 clk per tick, DEB_TICKS=3
module tb_hand_sensor_encoder;
   import hand_pkg::*;
   logic       clk = 1'b0;
   logic       reset;
   logic       sens_a, sens_b;
   logic [1:0] hand;
   logic       hand_valid;
   logic       stuck;
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         p0;
   logic [3:0] seen = '0;

   hand_sensor_encoder #(
      .CLK_HZ(1000), .TICK_HZ(100), .DEB_TICKS(3), .STUCK_TICKS(20)
   ) dut (
      .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
      .hand(hand), .hand_valid(hand_valid), .stuck(stuck)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (hand_valid) pulses++;
      if (reset) seen = '0;
      else seen[hand] = 1'b1;
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      wait_n(2);
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      sens_a = 1'b0;
      sens_b = 1'b0;
      wait_n(2);
      chk("rst_hand", 32'(hand), 32'(HAND_NONE));
      chk("rst_valid", 32'(hand_valid), 0);
      chk("rst_stuck", 32'(stuck), 0);
      reset = 1'b0;
      wait_n(5);
      chk("post_rst_hand", 32'(hand), 32'(HAND_NONE));
      chk("post_rst_valid", 32'(hand_valid), 0);
      chk("post_rst_stuck", 32'(stuck), 0);

      do_reset();
      sens_a = 1'b1;
      p0 = pulses;
      wait_n(30);
      chk("a_before_commit", 32'(hand), 32'(HAND_NONE));
      wait_n(1);
      chk("a_hand_low", 32'(hand), 32'(HAND_LOW));
      chk("a_valid_pulse", 32'(hand_valid), 1);
      wait_n(1);
      chk("a_valid_drop", 32'(hand_valid), 0);
      wait_n(20);
      chk("a_one_pulse", pulses - p0, 1);
      chk("a_hand_held", 32'(hand), 32'(HAND_LOW));

      sens_a = 1'b0;
      do_reset();
      p0 = pulses;
      sens_b = 1'b1;
      wait_n(20);
      sens_b = 1'b0;
      wait_n(50);
      chk("glitch_hand", 32'(hand), 32'(HAND_NONE));
      chk("glitch_no_pulse", pulses - p0, 0);

      do_reset();
      p0 = pulses;
      sens_a = 1'b1;
      sens_b = 1'b1;
      wait_n(30);
      chk("both_before", 32'(hand), 32'(HAND_NONE));
      wait_n(1);
      chk("both_hand", 32'(hand), 32'(HAND_BOTH));
      chk("both_valid", 32'(hand_valid), 1);
      wait_n(10);
      chk("both_one_pulse", pulses - p0, 1);
      chk("both_no_low", 32'(seen[1]), 0);
      chk("both_no_high", 32'(seen[2]), 0);

`ifdef HAND_STUCK_EN
      do_reset();
      wait_n(31);
      chk("stk_hand_both", 32'(hand), 32'(HAND_BOTH));
      p0 = pulses;
      wait_n(198);
      chk("stk_before_trip", 32'(hand), 32'(HAND_BOTH));
      chk("stk_flag_low", 32'(stuck), 0);
      wait_n(1);
      chk("stk_hand_none", 32'(hand), 32'(HAND_NONE));
      chk("stk_flag", 32'(stuck), 1);
      chk("stk_valid", 32'(hand_valid), 1);
      sens_a = 1'b0;
      sens_b = 1'b0;
      wait_n(30);
      chk("stk_still_set", 32'(stuck), 1);
      wait_n(1);
      chk("stk_cleared", 32'(stuck), 0);
      chk("stk_clear_hand", 32'(hand), 32'(HAND_NONE));
      chk("stk_clear_novalid", 32'(hand_valid), 0);
      wait_n(10);
      chk("stk_one_pulse", pulses - p0, 1);
`else
      wait_n(250);
      chk("nostk_hand", 32'(hand), 32'(HAND_BOTH));
      chk("nostk_flag", 32'(stuck), 0);
`endif

      sens_a = 1'b0;
      sens_b = 1'b0;
      do_reset();
      sens_a = 1'b1;
      wait_n(25);
      reset = 1'b1;
      #1;
      chk("mid_rst_hand", 32'(hand), 32'(HAND_NONE));
      wait_n(1);
      reset = 1'b0;
      p0 = pulses;
      wait_n(30);
      chk("mid_rst_fresh", 32'(hand), 32'(HAND_NONE));
      wait_n(1);
      chk("mid_rst_low", 32'(hand), 32'(HAND_LOW));
      chk("mid_rst_valid", 32'(hand_valid), 1);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_hand", 32'(hand), 32'(HAND_NONE));
      chk("async_rst_valid", 32'(hand_valid), 0);
      wait_n(1);
      reset = 1'b0;
      chk("mid_rst_pulses", pulses - p0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
